// File: rtl/keccak_pkg.sv
// Shared Keccak sequencing types: scheduler states, operation modes, round count
// and the rate lookup used to size each squeezed block.
package keccak_pkg;

  localparam int ROUNDS = 24;
  localparam int SIZE_W = 32;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'b00,
    MODE_SHAKE256 = 2'b01,
    MODE_SHA3_256 = 2'b10,
    MODE_SHA3_512 = 2'b11
  } op_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    ABSORB,
    PERMUTE,
    WAIT_OUT,
    SQUEEZE,
    FINISH
  } sched_state_t;

  // Rate in bits: the part of the 1600-bit state that is absorbed into / squeezed from.
  function automatic logic [SIZE_W-1:0] rate_bits(input op_mode_t mode);
    case (mode)
      MODE_SHAKE128: rate_bits = 32'd1344;
      MODE_SHAKE256: rate_bits = 32'd1088;
      MODE_SHA3_256: rate_bits = 32'd1088;
      default:       rate_bits = 32'd576;
    endcase
  endfunction

endpackage

// File: rtl/round_counter.sv
// Modulo counter that walks the permutation round index. Clear wins over enable;
// terminal flags the final round so the scheduler can leave PERMUTE on time.
module round_counter
  import keccak_pkg::*;
#(
  parameter int MODULUS = ROUNDS,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == CNT_W'(MODULUS - 1));

  // Count up while enabled, wrap after the last round, hold at zero while cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/permutation_scheduler.sv
// Sequences the Keccak state datapath: absorbs rate blocks from the load stage,
// runs the round permutation, and squeezes rate blocks into the output buffer
// until the requested output length has been produced.
module permutation_scheduler
  import keccak_pkg::*;
#(
  parameter int ROUNDS = keccak_pkg::ROUNDS,
  parameter int SIZE_W = keccak_pkg::SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              copy_control_regs_en,
  input  logic [1:0]        operation_mode_i,
  input  logic [SIZE_W-1:0] output_size_i,
  input  logic              input_buffer_ready,
  input  logic              last_block_in_buffer,
  output logic              input_buffer_consume,
  output logic              state_clear,
  output logic              absorb_en,
  output logic              round_en,
  output logic [4:0]        round_idx,
  input  logic              output_buffer_free,
  output logic              squeeze_en,
  output logic              last_output_block,
  output logic              busy,
  output logic              done
);

  sched_state_t      state, state_next;
  op_mode_t          mode_q, shadow_mode;
  logic [SIZE_W-1:0] remaining, shadow_size, rate;
  logic              pending, is_last, start;
  logic              rc_terminal;

  assign rate  = SIZE_W'(rate_bits(mode_q));
  assign start = (state == IDLE) && (copy_control_regs_en || pending);
  assign busy  = (state != IDLE);

  round_counter #(
    .MODULUS (ROUNDS),
    .CNT_W   (5)
  ) u_round_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != PERMUTE),
    .enable   (state == PERMUTE),
    .count    (round_idx),
    .terminal (rc_terminal)
  );

  // State register; reset drops any message in flight straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and strobes; a free output buffer at the last round skips WAIT_OUT.
  always_comb begin
    state_next           = state;
    state_clear          = 1'b0;
    absorb_en            = 1'b0;
    input_buffer_consume = 1'b0;
    round_en             = 1'b0;
    squeeze_en           = 1'b0;
    last_output_block    = 1'b0;
    done                 = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_clear = 1'b1;
          state_next  = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (input_buffer_ready) state_next = ABSORB;
      end
      ABSORB: begin
        absorb_en            = 1'b1;
        input_buffer_consume = 1'b1;
        state_next           = PERMUTE;
      end
      PERMUTE: begin
        round_en = 1'b1;
        if (rc_terminal) begin
          if (!is_last)                state_next = WAIT_IN;
          else if (remaining == '0)    state_next = FINISH;
          else if (output_buffer_free) state_next = SQUEEZE;
          else                         state_next = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (output_buffer_free) state_next = SQUEEZE;
      end
      SQUEEZE: begin
        squeeze_en = 1'b1;
        if (remaining <= rate) begin
          last_output_block = 1'b1;
          state_next        = FINISH;
        end else begin
          state_next = PERMUTE;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Message context: mode and bits still owed; compare before subtract keeps remaining from wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_SHAKE128;
      remaining <= '0;
      is_last   <= 1'b0;
    end else begin
      if (start) begin
        if (pending) begin
          mode_q    <= shadow_mode;
          remaining <= shadow_size;
        end else begin
          mode_q    <= op_mode_t'(operation_mode_i);
          remaining <= output_size_i;
        end
      end
      if (state == WAIT_IN && input_buffer_ready) is_last <= last_block_in_buffer;
      if (state == SQUEEZE && remaining > rate)   remaining <= remaining - rate;
    end
  end

  // One-deep holding slot for a copy that arrives while busy or while IDLE drains the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= 1'b0;
      shadow_mode <= MODE_SHAKE128;
      shadow_size <= '0;
    end else if (copy_control_regs_en && (state != IDLE || pending)) begin
      pending     <= 1'b1;
      shadow_mode <= op_mode_t'(operation_mode_i);
      shadow_size <= output_size_i;
    end else if (state == IDLE && pending) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_permutation_scheduler.sv
// Self-checking bench for permutation_scheduler: emulates the load and output
// stages, logs every strobe with its cycle number, and checks the log against
// block/squeeze counts and timing computed from the rate table.
module tb_permutation_scheduler;

  localparam int R = 24;

  logic        clk;
  logic        rst;
  logic        copy_control_regs_en;
  logic [1:0]  operation_mode_i;
  logic [31:0] output_size_i;
  logic        input_buffer_ready;
  logic        last_block_in_buffer;
  logic        input_buffer_consume;
  logic        state_clear;
  logic        absorb_en;
  logic        round_en;
  logic [4:0]  round_idx;
  logic        output_buffer_free;
  logic        squeeze_en;
  logic        last_output_block;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int blocks_left = 0;
  int free_release_at = -1;
  bit random_free = 1'b0;

  int absorb_q[$], consume_q[$], round_q[$], idx_q[$];
  int squeeze_q[$], last_q[$], done_q[$], clear_q[$];

  permutation_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .copy_control_regs_en (copy_control_regs_en),
    .operation_mode_i     (operation_mode_i),
    .output_size_i        (output_size_i),
    .input_buffer_ready   (input_buffer_ready),
    .last_block_in_buffer (last_block_in_buffer),
    .input_buffer_consume (input_buffer_consume),
    .state_clear          (state_clear),
    .absorb_en            (absorb_en),
    .round_en             (round_en),
    .round_idx            (round_idx),
    .output_buffer_free   (output_buffer_free),
    .squeeze_en           (squeeze_en),
    .last_output_block    (last_output_block),
    .busy                 (busy),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rate_of(input int m);
    case (m)
      0:       return 1344;
      1, 2:    return 1088;
      default: return 576;
    endcase
  endfunction

  function automatic int squeezes_for(input int size, input int m);
    if (size == 0) return 0;
    return (size + rate_of(m) - 1) / rate_of(m);
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int count_between(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[k]) if (q[k] > lo && q[k] < hi) n++;
    return n;
  endfunction

  function automatic logic [12:0] out_vec();
    return {state_clear, absorb_en, input_buffer_consume, round_en, round_idx,
            squeeze_en, last_output_block, done, busy};
  endfunction

  task automatic clear_log();
    absorb_q.delete(); consume_q.delete(); round_q.delete(); idx_q.delete();
    squeeze_q.delete(); last_q.delete(); done_q.delete(); clear_q.delete();
  endtask

  task automatic set_blocks(input int n);
    blocks_left          = n;
    input_buffer_ready   = (n > 0);
    last_block_in_buffer = (n == 1);
  endtask

  // One clock: log strobes at the falling edge, then react like the neighbouring stages.
  task automatic tick();
    logic saw_consume;
    @(negedge clk);
    cyc++;
    saw_consume = input_buffer_consume;
    if (absorb_en)            absorb_q.push_back(cyc);
    if (input_buffer_consume) consume_q.push_back(cyc);
    if (round_en) begin
      round_q.push_back(cyc);
      idx_q.push_back(int'(round_idx));
    end
    if (squeeze_en)        squeeze_q.push_back(cyc);
    if (last_output_block) last_q.push_back(cyc);
    if (done)              done_q.push_back(cyc);
    if (state_clear)       clear_q.push_back(cyc);
    @(posedge clk);
    #1;
    copy_control_regs_en = 1'b0;
    if (saw_consume && blocks_left > 0) set_blocks(blocks_left - 1);
    if (random_free) output_buffer_free = ($urandom_range(0, 1) == 1);
    else if (cyc == free_release_at) output_buffer_free = 1'b1;
  endtask

  task automatic start_msg(input int m, input int sz, input int nb);
    set_blocks(nb);
    operation_mode_i     = 2'(m);
    output_size_i        = 32'(sz);
    copy_control_regs_en = 1'b1;
    tick();
  endtask

  task automatic run_until_done(input int n_done, input int budget, output bit ok);
    int k = 0;
    while (done_q.size() < n_done && k < budget) begin
      tick();
      k++;
    end
    ok = (done_q.size() >= n_done);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++; if (out_vec() !== 13'd0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want 0", out_vec()); end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_log();
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (clear_q.size() + done_q.size() !== 0) begin bad++; $display("[TB] FAIL reset_quiet: got %0d strobes want 0", clear_q.size() + done_q.size()); end
  endtask

  task automatic test_single_block();
    bit ok; int t, errs;
    clear_log();
    start_msg(0, 256, 1);
    run_until_done(1, 200, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL t1_timeout: got no done want done"); end
    t = qat(absorb_q, 0);
    total++; if (qat(clear_q, 0) !== t - 2) begin bad++; $display("[TB] FAIL t1_clear: got %0d want %0d", qat(clear_q, 0), t - 2); end
    total++; if (qat(consume_q, 0) !== t) begin bad++; $display("[TB] FAIL t1_consume: got %0d want %0d", qat(consume_q, 0), t); end
    total++; if (round_q.size() !== R) begin bad++; $display("[TB] FAIL t1_rounds: got %0d want %0d", round_q.size(), R); end
    total++; if (qat(round_q, 0) !== t + 1) begin bad++; $display("[TB] FAIL t1_first_round: got %0d want %0d", qat(round_q, 0), t + 1); end
    total++; if (qat(round_q, R - 1) !== t + R) begin bad++; $display("[TB] FAIL t1_last_round: got %0d want %0d", qat(round_q, R - 1), t + R); end
    errs = 0;
    foreach (idx_q[k]) if (idx_q[k] != k % R) errs++;
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL t1_round_idx: got %0d bad indices want 0", errs); end
    total++; if (qat(squeeze_q, 0) !== t + R + 1) begin bad++; $display("[TB] FAIL t1_squeeze: got %0d want %0d", qat(squeeze_q, 0), t + R + 1); end
    total++; if (qat(last_q, 0) !== t + R + 1) begin bad++; $display("[TB] FAIL t1_last_block: got %0d want %0d", qat(last_q, 0), t + R + 1); end
    total++; if (qat(done_q, 0) !== t + R + 2) begin bad++; $display("[TB] FAIL t1_done: got %0d want %0d", qat(done_q, 0), t + R + 2); end
  endtask

  task automatic test_multi_squeeze();
    bit ok;
    clear_log();
    start_msg(1, 2176, 1);
    run_until_done(1, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL t2a_timeout: got no done want done"); end
    total++; if (squeeze_q.size() !== 2) begin bad++; $display("[TB] FAIL t2a_squeezes: got %0d want 2", squeeze_q.size()); end
    total++; if (qat(squeeze_q, 1) - qat(squeeze_q, 0) !== R + 1) begin bad++; $display("[TB] FAIL t2a_gap: got %0d want %0d", qat(squeeze_q, 1) - qat(squeeze_q, 0), R + 1); end
    total++; if (count_between(round_q, qat(squeeze_q, 0), qat(squeeze_q, 1)) !== R) begin bad++; $display("[TB] FAIL t2a_mid_rounds: got %0d want %0d", count_between(round_q, qat(squeeze_q, 0), qat(squeeze_q, 1)), R); end
    total++; if (last_q.size() !== 1 || qat(last_q, 0) !== qat(squeeze_q, 1)) begin bad++; $display("[TB] FAIL t2a_last: got %0d want %0d", qat(last_q, 0), qat(squeeze_q, 1)); end
    clear_log();
    start_msg(1, 2177, 1);
    run_until_done(1, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL t2b_timeout: got no done want done"); end
    total++; if (squeeze_q.size() !== 3) begin bad++; $display("[TB] FAIL t2b_squeezes: got %0d want 3", squeeze_q.size()); end
    total++; if (last_q.size() !== 1 || qat(last_q, 0) !== qat(squeeze_q, 2)) begin bad++; $display("[TB] FAIL t2b_last: got %0d want %0d", qat(last_q, 0), qat(squeeze_q, 2)); end
  endtask

  task automatic test_multi_block();
    bit ok;
    clear_log();
    start_msg(2, 256, 3);
    run_until_done(1, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL t3_timeout: got no done want done"); end
    total++; if (consume_q.size() !== 3) begin bad++; $display("[TB] FAIL t3_consumes: got %0d want 3", consume_q.size()); end
    total++; if (count_between(round_q, 0, qat(squeeze_q, 0)) !== 3 * R) begin bad++; $display("[TB] FAIL t3_rounds: got %0d want %0d", count_between(round_q, 0, qat(squeeze_q, 0)), 3 * R); end
    total++; if (squeeze_q.size() !== 1 || qat(squeeze_q, 0) <= qat(consume_q, 2)) begin bad++; $display("[TB] FAIL t3_squeeze: got %0d squeezes at %0d want 1 after %0d", squeeze_q.size(), qat(squeeze_q, 0), qat(consume_q, 2)); end
  endtask

  task automatic test_backpressure();
    bit ok; int c, k;
    clear_log();
    output_buffer_free = 1'b0;
    start_msg(0, 256, 1);
    k = 0;
    while (round_q.size() < R && k < 200) begin tick(); k++; end
    c = qat(round_q, R - 1);
    free_release_at = c + 9;
    run_until_done(1, 200, ok);
    free_release_at = -1;
    output_buffer_free = 1'b1;
    total++; if (!ok) begin bad++; $display("[TB] FAIL t4_timeout: got no done want done"); end
    total++; if (qat(squeeze_q, 0) !== c + 11) begin bad++; $display("[TB] FAIL t4_squeeze: got %0d want %0d", qat(squeeze_q, 0), c + 11); end
    total++; if (round_q.size() !== R) begin bad++; $display("[TB] FAIL t4_stall_rounds: got %0d want %0d", round_q.size(), R); end
  endtask

  task automatic test_back_to_back();
    bit ok; int d, k;
    clear_log();
    start_msg(3, 512, 1);
    k = 0;
    while (round_q.size() < 6 && k < 100) begin tick(); k++; end
    operation_mode_i     = 2'd0;
    output_size_i        = 32'd1345;
    copy_control_regs_en = 1'b1;
    tick();
    run_until_done(1, 200, ok);
    d = qat(done_q, 0);
    set_blocks(1);
    run_until_done(2, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL t5_timeout: got %0d dones want 2", done_q.size()); end
    total++; if (qat(clear_q, 1) !== d + 1) begin bad++; $display("[TB] FAIL t5_clear: got %0d want %0d", qat(clear_q, 1), d + 1); end
    total++; if (count_between(squeeze_q, 0, d) !== 1) begin bad++; $display("[TB] FAIL t5_a_squeezes: got %0d want 1", count_between(squeeze_q, 0, d)); end
    total++; if (count_between(squeeze_q, d, cyc + 1) !== squeezes_for(1345, 0)) begin bad++; $display("[TB] FAIL t5_b_squeezes: got %0d want %0d", count_between(squeeze_q, d, cyc + 1), squeezes_for(1345, 0)); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_log();
    start_msg(0, 256, 1);
    k = 0;
    while (qat(idx_q, idx_q.size() - 1) != 11 && k < 100) begin tick(); k++; end
    total++; if (round_idx !== 5'd12) begin bad++; $display("[TB] FAIL t6_round12: got %0d want 12", round_idx); end
    rst = 1'b0;
    #1;
    total++; if (out_vec() !== 13'd0) begin bad++; $display("[TB] FAIL t6_outputs: got %h want 0", out_vec()); end
    @(posedge clk); #1;
    rst = 1'b1;
    set_blocks(0);
    clear_log();
    repeat (30) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_busy: got %b want 0", busy); end
    total++; if (done_q.size() + clear_q.size() !== 0) begin bad++; $display("[TB] FAIL t6_quiet: got %0d strobes want 0", done_q.size() + clear_q.size()); end
  endtask

  task automatic test_zero_size();
    bit ok;
    clear_log();
    start_msg(0, 0, 1);
    run_until_done(1, 200, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL t7_timeout: got no done want done"); end
    total++; if (squeeze_q.size() + last_q.size() !== 0) begin bad++; $display("[TB] FAIL t7_squeeze: got %0d want 0", squeeze_q.size() + last_q.size()); end
    total++; if (qat(done_q, 0) !== qat(round_q, R - 1) + 1) begin bad++; $display("[TB] FAIL t7_done: got %0d want %0d", qat(done_q, 0), qat(round_q, R - 1) + 1); end
  endtask

  task automatic test_random();
    bit ok; int m, sz, nb, nsq, nr, errs;
    random_free = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m   = int'($urandom_range(0, 3));
      nb  = int'($urandom_range(1, 3));
      sz  = int'($urandom_range(0, 3 * rate_of(m)));
      nsq = squeezes_for(sz, m);
      nr  = R * (nb + ((nsq > 1) ? nsq - 1 : 0));
      clear_log();
      start_msg(m, sz, nb);
      run_until_done(1, 3000, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL rnd%0d_timeout: got no done want done", i); end
      total++; if (consume_q.size() !== nb) begin bad++; $display("[TB] FAIL rnd%0d_consumes: got %0d want %0d", i, consume_q.size(), nb); end
      total++; if (squeeze_q.size() !== nsq) begin bad++; $display("[TB] FAIL rnd%0d_squeezes: got %0d want %0d (mode %0d size %0d)", i, squeeze_q.size(), nsq, m, sz); end
      total++; if (round_q.size() !== nr) begin bad++; $display("[TB] FAIL rnd%0d_rounds: got %0d want %0d", i, round_q.size(), nr); end
      total++; if (last_q.size() !== ((nsq > 0) ? 1 : 0) || qat(last_q, 0) !== ((nsq > 0) ? qat(squeeze_q, nsq - 1) : -1)) begin bad++; $display("[TB] FAIL rnd%0d_last: got %0d want %0d", i, qat(last_q, 0), qat(squeeze_q, nsq - 1)); end
      errs = 0;
      foreach (idx_q[k]) if (idx_q[k] != k % R) errs++;
      total++; if (errs !== 0) begin bad++; $display("[TB] FAIL rnd%0d_round_idx: got %0d bad indices want 0", i, errs); end
    end
    random_free = 1'b0;
    output_buffer_free = 1'b1;
  endtask

  initial begin
    rst                  = 1'b0;
    copy_control_regs_en = 1'b0;
    operation_mode_i     = 2'd0;
    output_size_i        = 32'd0;
    input_buffer_ready   = 1'b0;
    last_block_in_buffer = 1'b0;
    output_buffer_free   = 1'b1;
    $display("[TB] starting permutation_scheduler bench");
    test_reset();
    test_single_block();
    test_multi_squeeze();
    test_multi_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_size();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
